// File: rtl/adder_tb_pkg.sv
// Shared constants, state encoding and MISR step for the adder test bench.
package adder_tb_pkg;

    localparam int unsigned SIG_W     = 16;
    localparam logic [15:0] MISR_TAPS = 16'hE010;
    localparam logic [15:0] SIG_INIT  = 16'h0000;
    localparam logic [15:0] NO_ERR    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ora_state_e;

    // One MISR/LFSR shift with feedback from the tap mask, then fold in the data word.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
        return {sig[14:0], ^(sig & MISR_TAPS)} ^ data;
    endfunction

endpackage

// File: rtl/adder_ora_delay.sv
// LATENCY-stage delay line carrying a valid flag and a data word.
module adder_ora_delay #(
    parameter int unsigned W       = 17,
    parameter int unsigned LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [LATENCY-1:0] v_q;
    logic [W-1:0]       d_q [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= valid_i;
            d_q[0] <= data_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign valid_o = v_q[LATENCY-1];
    assign data_o  = d_q[LATENCY-1];

endmodule

// File: rtl/adder_ora.sv
// Output response analyser: checks adder results against a delayed reference,
// compacts sums into a MISR and reports a sticky verdict after PATTERNS compares.
module adder_ora
    import adder_tb_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PATTERNS = 100,
    parameter int unsigned LATENCY  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err,
    output logic [15:0]      signature
);

    localparam int unsigned EW = WIDTH + 1;

    logic [EW-1:0] exp_c;
    logic          cmp_v;
    logic [EW-1:0] cmp_e;
    logic          mismatch_c;
    logic          compare_c;
    logic [15:0]   sum16_c;

    ora_state_e  state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] err_q, err_d;
    logic [15:0] first_q, first_d;
    logic [15:0] sig_q, sig_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    assign exp_c = EW'(a) + EW'(b);

    adder_ora_delay #(
        .W       (EW),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid),
        .data_i  (exp_c),
        .valid_o (cmp_v),
        .data_o  (cmp_e)
    );

    assign mismatch_c = ({cout, sum} != cmp_e);
    assign sum16_c    = SIG_W'(sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= NO_ERR;
            sig_q   <= SIG_INIT;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next state, counters and MISR; DONE accepts nothing further.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        first_d   = first_q;
        sig_d     = sig_q;
        done_d    = done_q;
        pass_d    = pass_q;
        compare_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmp_v) begin
                    compare_c = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                compare_c = cmp_v;
            end
            DONE: begin
                compare_c = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (compare_c) begin
            idx_d = idx_q + 16'd1;
            sig_d = misr_step(sig_q, sum16_c);
            if (mismatch_c) begin
                if (err_q != NO_ERR) begin
                    err_d = err_q + 16'd1;
                end
                if (first_q == NO_ERR) begin
                    first_d = idx_q;
                end
            end
            if (idx_d == 16'(PATTERNS)) begin
                state_d = DONE;
                done_d  = 1'b1;
                pass_d  = (err_d == 16'd0);
            end
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign first_err = first_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_adder_ora.sv
// Scoreboard bench for adder_ora: several instances with different PATTERNS/LATENCY
// are fed by a behavioural adder with optional fault injection.
`timescale 1ns/1ps
module tb_adder_ora;

    localparam int unsigned W       = 16;
    localparam int unsigned P_SMALL = 4;
    localparam int unsigned P_BIG   = 37;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] fs;
        logic        fc;
    } pat_t;

    typedef struct packed {
        logic [15:0] err;
        logic [15:0] first;
        logic [15:0] sig;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic [15:0] a, b, fs;
    logic        fc;

    int checks   = 0;
    int failures = 0;

    // Behavioural adder: sum/cout of the pattern captured D edges ago, with fault masks applied.
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic [15:0] pfs [4];
    logic        pfc [4];
    always_ff @(posedge clk) begin
        pa[0] <= a; pb[0] <= b; pfs[0] <= fs; pfc[0] <= fc;
        for (int i = 1; i < 4; i++) begin
            pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; pfs[i] <= pfs[i-1]; pfc[i] <= pfc[i-1];
        end
    end

    logic [16:0] r1, r2, r3;
    assign r1 = ({1'b0, pa[0]} + {1'b0, pb[0]}) ^ {pfc[0], pfs[0]};
    assign r2 = ({1'b0, pa[1]} + {1'b0, pb[1]}) ^ {pfc[1], pfs[1]};
    assign r3 = ({1'b0, pa[2]} + {1'b0, pb[2]}) ^ {pfc[2], pfs[2]};

    // 0: P=4 L=1, 1: P=4 L=3, 2: P=37 L=2, 3: P=4 L=2 fed by a 3-cycle adder
    logic        done_o  [4];
    logic        pass_o  [4];
    logic [15:0] err_o   [4];
    logic [15:0] first_o [4];
    logic [15:0] sig_o   [4];

    adder_ora #(.WIDTH(W), .PATTERNS(P_SMALL), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .valid(valid), .a(a), .b(b), .sum(r1[15:0]), .cout(r1[16]),
        .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]), .first_err(first_o[0]),
        .signature(sig_o[0]));

    adder_ora #(.WIDTH(W), .PATTERNS(P_SMALL), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .valid(valid), .a(a), .b(b), .sum(r3[15:0]), .cout(r3[16]),
        .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]), .first_err(first_o[1]),
        .signature(sig_o[1]));

    adder_ora #(.WIDTH(W), .PATTERNS(P_BIG), .LATENCY(2)) u_big (
        .clk(clk), .rst(rst), .valid(valid), .a(a), .b(b), .sum(r2[15:0]), .cout(r2[16]),
        .done(done_o[2]), .pass(pass_o[2]), .err_count(err_o[2]), .first_err(first_o[2]),
        .signature(sig_o[2]));

    adder_ora #(.WIDTH(W), .PATTERNS(P_SMALL), .LATENCY(2)) u_l2x (
        .clk(clk), .rst(rst), .valid(valid), .a(a), .b(b), .sum(r3[15:0]), .cout(r3[16]),
        .done(done_o[3]), .pass(pass_o[3]), .err_count(err_o[3]), .first_err(first_o[3]),
        .signature(sig_o[3]));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: verdict from the first p patterns, by the adder/MISR rules.
    function automatic res_t model(input pat_t pl[$], input int unsigned p);
        res_t r;
        r.err   = 16'd0;
        r.first = 16'hFFFF;
        r.sig   = 16'h0000;
        for (int unsigned i = 0; i < p; i++) begin
            logic [15:0] s;
            logic        fb;
            s  = (pl[i].a + pl[i].b) ^ pl[i].fs;
            fb = r.sig[15] ^ r.sig[14] ^ r.sig[13] ^ r.sig[4];
            r.sig = {r.sig[14:0], fb} ^ s;
            if (pl[i].fs != 16'd0 || pl[i].fc) begin
                if (r.err != 16'hFFFF) r.err = r.err + 16'd1;
                if (r.first == 16'hFFFF) r.first = 16'(i);
            end
        end
        r.pass = (r.err == 16'd0);
        return r;
    endfunction

    // Scoreboard and monitor: pop on each done rise, then demand frozen outputs while done holds.
    res_t sb [3][$];
    logic done_prev [3];
    res_t held [3];

    always @(negedge clk) begin
        res_t got;
        res_t e;
        for (int i = 0; i < 3; i++) begin
            got = {err_o[i], first_o[i], sig_o[i], pass_o[i]};
            if (done_o[i] && !done_prev[i]) begin
                if (sb[i].size() == 0) begin
                    chk($sformatf("sb%0d_unexpected_done", i), 64'd1, 64'd0);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("sb%0d_err_count", i), 64'(got.err),   64'(e.err));
                    chk($sformatf("sb%0d_first_err", i), 64'(got.first), 64'(e.first));
                    chk($sformatf("sb%0d_signature", i), 64'(got.sig),   64'(e.sig));
                    chk($sformatf("sb%0d_pass", i),      64'(got.pass),  64'(e.pass));
                end
                held[i] = got;
            end else if (done_o[i] && done_prev[i]) begin
                chk($sformatf("absorb%0d", i), 64'(got), 64'(held[i]));
            end
            done_prev[i] = done_o[i];
        end
    end

    task automatic drive(input pat_t p);
        valid = 1'b1; a = p.a; b = p.b; fs = p.fs; fc = p.fc;
        @(posedge clk); #1;
        valid = 1'b0; a = 16'($urandom); b = 16'($urandom); fs = 16'd0; fc = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0; valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_done%0d", tag, i),  64'(done_o[i]),  64'd0);
            chk($sformatf("%s_pass%0d", tag, i),  64'(pass_o[i]),  64'd0);
            chk($sformatf("%s_err%0d", tag, i),   64'(err_o[i]),   64'd0);
            chk($sformatf("%s_first%0d", tag, i), 64'(first_o[i]), 64'hFFFF);
            chk($sformatf("%s_sig%0d", tag, i),   64'(sig_o[i]),   64'h0000);
        end
    endtask

    task automatic push_exp(input pat_t pl[$]);
        if (pl.size() >= P_SMALL) begin
            sb[0].push_back(model(pl, P_SMALL));
            sb[1].push_back(model(pl, P_SMALL));
        end
        if (pl.size() >= P_BIG) sb[2].push_back(model(pl, P_BIG));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drain", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
        for (int i = 0; i < 3; i++) sb[i].delete();
    endtask

    // gap < 0 selects random idle cycles between patterns.
    task automatic run(input pat_t pl[$], input int gap);
        push_exp(pl);
        foreach (pl[i]) begin
            drive(pl[i]);
            if (i != pl.size() - 1) idle(gap < 0 ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2)) : gap);
        end
        wait_drain();
    endtask

    pat_t clean[$];
    pat_t faulty[$];
    pat_t rnd[$];
    pat_t p;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; valid = 1'b0; a = 16'd0; b = 16'd0; fs = 16'd0; fc = 1'b0;
        clean.push_back({16'd1,      16'd2,      16'd0, 1'b0});
        clean.push_back({16'hFFFF,   16'd1,      16'd0, 1'b0});
        clean.push_back({16'h8000,   16'h8000,   16'd0, 1'b0});
        clean.push_back({16'd0,      16'd0,      16'd0, 1'b0});
        faulty = clean;
        faulty[0].fs = 16'd1;
        faulty[2].fc = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b1;

        // Clean back-to-back run with signature trace and done timing on the L=1 instance.
        push_exp(clean);
        drive(clean[0]);
        drive(clean[1]); chk("clean_sig0", 64'(sig_o[0]), 64'h0003);
        drive(clean[2]); chk("clean_sig1", 64'(sig_o[0]), 64'h0006);
        drive(clean[3]); chk("clean_sig2", 64'(sig_o[0]), 64'h000C);
        chk("clean_done_early", 64'(done_o[0]), 64'd0);
        idle(1);
        chk("clean_sig3", 64'(sig_o[0]), 64'h0018);
        chk("clean_done", 64'(done_o[0]), 64'd1);
        chk("clean_pass", 64'(pass_o[0]), 64'd1);
        chk("clean_err", 64'(err_o[0]), 64'd0);
        chk("clean_first", 64'(first_o[0]), 64'hFFFF);
        idle(3);
        chk("l3_pass", 64'(pass_o[1]), 64'd1);
        chk("l2x_err_nonzero", 64'(err_o[3] != 16'd0), 64'd1);
        chk("l2x_pass", 64'(pass_o[3]), 64'd0);
        wait_drain();

        // Absorption: faulty patterns after done must change nothing.
        for (int i = 0; i < 4; i++) drive({16'($urandom), 16'($urandom), 16'h00FF, 1'b1});
        idle(4);
        chk("absorb_sig", 64'(sig_o[0]), 64'h0018);
        chk("absorb_err", 64'(err_o[0]), 64'd0);
        chk("absorb_done", 64'(done_o[0]), 64'd1);

        // Injected faults.
        do_reset();
        run(faulty, 0);
        chk("fault_err", 64'(err_o[0]), 64'd2);
        chk("fault_first", 64'(first_o[0]), 64'd0);
        chk("fault_pass", 64'(pass_o[0]), 64'd0);

        // Three idle cycles between patterns.
        do_reset();
        push_exp(clean);
        for (int i = 0; i < 4; i++) begin
            drive(clean[i]);
            if (i != 3) idle(3);
        end
        chk("gap_done_early", 64'(done_o[0]), 64'd0);
        idle(1);
        chk("gap_done", 64'(done_o[0]), 64'd1);
        chk("gap_sig", 64'(sig_o[0]), 64'h0018);
        wait_drain();

        // Reset after two compares, then a clean rerun.
        do_reset();
        drive(clean[0]); drive(clean[1]); drive(clean[2]);
        #2 rst = 1'b0;
        #1 chk_reset("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run(clean, 0);
        chk("rerun_pass", 64'(pass_o[0]), 64'd1);
        chk("rerun_sig", 64'(sig_o[0]), 64'h0018);

        // Randomised runs with sparse faults and random gaps.
        for (int r = 0; r < 12; r++) begin
            do_reset();
            rnd.delete();
            for (int i = 0; i < int'($urandom_range(37, 45)); i++) begin
                p.a  = 16'($urandom);
                p.b  = 16'($urandom);
                p.fs = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'd0;
                p.fc = ($urandom_range(0, 15) == 0);
                rnd.push_back(p);
            end
            run(rnd, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
